// File: rtl/prescaler_burst_if.sv
// Control/status bundle between a serial-protocol engine and the SCK prescaler.
// o_period_cnt is present only when PRESCALER_BURST_PCNT_EN is defined.
interface prescaler_burst_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
);
  logic             i_module_en;
  logic             i_ld;
  logic [DIV_W-1:0] i_ld_data;
  logic             i_cpol;
  logic             i_start;
  logic [CNT_W-1:0] i_burst_len;
  logic             i_stop;
  logic             o_sclk;
  logic             o_sclk_rise;
  logic             o_sclk_fall;
  logic             o_busy;
  logic             o_done;
`ifdef PRESCALER_BURST_PCNT_EN
  logic [CNT_W-1:0] o_period_cnt;
`endif

  modport master (
    output i_module_en, i_ld, i_ld_data, i_cpol, i_start, i_burst_len, i_stop,
`ifdef PRESCALER_BURST_PCNT_EN
    input  o_period_cnt,
`endif
    input  o_sclk, o_sclk_rise, o_sclk_fall, o_busy, o_done
  );

  modport slave (
    input  i_module_en, i_ld, i_ld_data, i_cpol, i_start, i_burst_len, i_stop,
`ifdef PRESCALER_BURST_PCNT_EN
    output o_period_cnt,
`endif
    output o_sclk, o_sclk_rise, o_sclk_fall, o_busy, o_done
  );
endinterface

// File: rtl/prescaler_burst.sv
// Programmable SCK generator: (div+1)-cycle half-period, CPOL idle level, N-period burst or free-run.
// Define PRESCALER_BURST_PCNT_EN to expose the completed-period counter as o_period_cnt.
module prescaler_burst #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic               i_sysclk,
  input  logic               i_sysrst,
  prescaler_burst_if.slave   bus
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] counter_q, counter_d;
  logic             phase_q, phase_d;
  logic             cpol_q, cpol_d;
  logic             stop_pend_q, stop_pend_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] blen_q, blen_d;
  logic [CNT_W-1:0] periods_q, periods_d;

  logic             run;
  logic             en;
  logic             tc;
  logic             trailing;
  logic             fixed_end;
  logic             complete;
  logic             start_acc;
  logic             sclk;
  logic [CNT_W-1:0] periods_inc;

  assign run         = (state_q == S_RUN);
  assign en          = bus.i_module_en;
  assign tc          = run && (counter_q == div_act_q);
  // phase_q==1 means SCK is away from its idle level, so this tc returns it home
  assign trailing    = tc && phase_q;
  assign periods_inc = periods_q + 1'b1;
  assign fixed_end   = (blen_q != '0) && (periods_inc == blen_q);
  assign complete    = en && trailing && (fixed_end || stop_pend_q);
  assign start_acc   = !run && en && bus.i_start;
  assign sclk        = phase_q ^ cpol_q;

  // State register
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.i_start) state_d = S_RUN;
        S_RUN:   if (complete)    state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.o_sclk      = sclk;
    bus.o_sclk_rise = tc && en && !sclk;
    bus.o_sclk_fall = tc && en && sclk;
    bus.o_busy      = run;
    bus.o_done      = done_q;
`ifdef PRESCALER_BURST_PCNT_EN
    bus.o_period_cnt = periods_q;
`endif
  end

  // Divider shadowing, counter/phase and burst bookkeeping
  always_comb begin
    div_pend_d = bus.i_ld ? bus.i_ld_data : div_pend_q;

    // Active divider only changes at a period boundary so a period never mixes two values
    div_act_d = div_act_q;
    if (!run || trailing) div_act_d = div_pend_q;

    cpol_d = run ? cpol_q : bus.i_cpol;

    counter_d = '0;
    phase_d   = 1'b0;
    if (run && en && !complete) begin
      counter_d = tc ? '0 : counter_q + 1'b1;
      phase_d   = tc ? !phase_q : phase_q;
    end

    blen_d      = blen_q;
    periods_d   = periods_q;
    stop_pend_d = 1'b0;
    if (start_acc) begin
      blen_d    = bus.i_burst_len;
      periods_d = '0;
    end else if (run && en) begin
      if (trailing) periods_d = periods_inc;
      stop_pend_d = (stop_pend_q || bus.i_stop) && !complete;
    end

    done_d = complete;
  end

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      div_pend_q  <= '0;
      div_act_q   <= '0;
      counter_q   <= '0;
      phase_q     <= 1'b0;
      cpol_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      blen_q      <= '0;
      periods_q   <= '0;
    end else begin
      div_pend_q  <= div_pend_d;
      div_act_q   <= div_act_d;
      counter_q   <= counter_d;
      phase_q     <= phase_d;
      cpol_q      <= cpol_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      blen_q      <= blen_d;
      periods_q   <= periods_d;
    end
  end

endmodule

// File: tb/tb_prescaler_burst.sv
// Self-checking bench for prescaler_burst: vector table, corner sequences, randomized bursts.
module tb_prescaler_burst;
  localparam int DIV_W = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  prescaler_burst_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus_if ();

  prescaler_burst #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .i_sysclk (clk),
    .i_sysrst (rst),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int div;
    int cpol;
    int blen;
    int exp_busy;
    int exp_rises;
    int exp_falls;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic prog(input int div, input int cpol);
    cyc();
    bus_if.i_ld      = 1'b1;
    bus_if.i_ld_data = DIV_W'(div);
    bus_if.i_cpol    = cpol[0];
    cyc();
    bus_if.i_ld = 1'b0;
    cyc();
  endtask

  task automatic start_burst(input int blen);
    cyc();
    bus_if.i_start     = 1'b1;
    bus_if.i_burst_len = CNT_W'(blen);
    cyc();
    bus_if.i_start = 1'b0;
  endtask

  // Reference: RUN cycle k has SCK = cpol ^ floor(k/h) mod 2; a strobe in the last cycle of each half-period
  task automatic run_burst(input int div, input int cpol, input int blen, input bit noise,
                           output int busy_n, output int rises, output int falls, output int dones);
    int  h;
    int  exp_busy;
    int  k;
    int  exp_s;
    bit  last;
    bit  finished;
    h        = div + 1;
    exp_busy = 2 * h * blen;
    busy_n = 0; rises = 0; falls = 0; dones = 0; k = 0; finished = 0;
    prog(div, cpol);
    smp();
    chk("idle_sclk", bus_if.o_sclk, cpol);
    chk("idle_busy", bus_if.o_busy, 0);
    start_burst(blen);
    for (int t = 0; t < exp_busy + 8; t++) begin
      if (t > 0) cyc();
      bus_if.i_start = (noise && k < exp_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      smp();
      if (bus_if.o_busy) begin
        exp_s = cpol ^ ((k / h) & 1);
        last  = ((k % h) == h - 1);
        chk("run_sclk", bus_if.o_sclk, exp_s);
        chk("run_rise", bus_if.o_sclk_rise, (last && exp_s == 0) ? 1 : 0);
        chk("run_fall", bus_if.o_sclk_fall, (last && exp_s == 1) ? 1 : 0);
        chk("done_in_run", bus_if.o_done, 0);
`ifdef PRESCALER_BURST_PCNT_EN
        chk("run_pcnt", bus_if.o_period_cnt, k / (2 * h));
`endif
        rises += int'(bus_if.o_sclk_rise);
        falls += int'(bus_if.o_sclk_fall);
        busy_n++;
        k++;
      end else begin
        chk("done_pulse", bus_if.o_done, 1);
        chk("end_sclk", bus_if.o_sclk, cpol);
        dones++;
        cyc();
        bus_if.i_start = 1'b0;
        smp();
        chk("done_single", bus_if.o_done, 0);
        chk("post_busy", bus_if.o_busy, 0);
`ifdef PRESCALER_BURST_PCNT_EN
        chk("hold_pcnt", bus_if.o_period_cnt, blen);
`endif
        finished = 1;
        break;
      end
    end
    if (!finished) chk("burst_timeout", 0, 1);
    bus_if.i_start = 1'b0;
  endtask

  initial begin
    vec_t tbl[6];
    int   busy_n, rises, falls, dones, k, div, cpol, blen;
    bit   seen;

    tbl[0] = '{2, 0, 3, 18, 3, 3};
    tbl[1] = '{0, 1, 2,  4, 2, 2};
    tbl[2] = '{1, 0, 1,  4, 1, 1};
    tbl[3] = '{3, 1, 2, 16, 2, 2};
    tbl[4] = '{0, 0, 1,  2, 1, 1};
    tbl[5] = '{4, 0, 2, 20, 2, 2};

    bus_if.i_module_en = 1'b1;
    bus_if.i_ld        = 1'b0;
    bus_if.i_ld_data   = '0;
    bus_if.i_cpol      = 1'b1;
    bus_if.i_start     = 1'b0;
    bus_if.i_burst_len = '0;
    bus_if.i_stop      = 1'b0;

    // Reset state (cpol input high, but the reset value must win)
    #3;
    chk("rst_sclk", bus_if.o_sclk, 0);
    chk("rst_busy", bus_if.o_busy, 0);
    chk("rst_done", bus_if.o_done, 0);
    chk("rst_rise", bus_if.o_sclk_rise, 0);
    chk("rst_fall", bus_if.o_sclk_fall, 0);
`ifdef PRESCALER_BURST_PCNT_EN
    chk("rst_pcnt", bus_if.o_period_cnt, 0);
`endif
    cyc(); cyc();
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_burst(tbl[i].div, tbl[i].cpol, tbl[i].blen, 1'b0, busy_n, rises, falls, dones);
      chk("tbl_busy", busy_n, tbl[i].exp_busy);
      chk("tbl_rises", rises, tbl[i].exp_rises);
      chk("tbl_falls", falls, tbl[i].exp_falls);
      chk("tbl_dones", dones, 1);
    end

    // Asynchronous reset in the middle of a run
    prog(3, 1);
    start_burst(5);
    for (int t = 0; t < 10; t++) cyc();
    smp();
    chk("pre_rst_busy", bus_if.o_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_sclk", bus_if.o_sclk, 0);
    chk("arst_busy", bus_if.o_busy, 0);
    chk("arst_done", bus_if.o_done, 0);
    chk("arst_strobe", {bus_if.o_sclk_rise, bus_if.o_sclk_fall}, 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    smp();
    chk("post_rst_done", bus_if.o_done, 0);

    // Free-running, graceful stop raised in the high phase of period 3
    prog(1, 0);
    start_burst(0);
    k = 0; seen = 0;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) cyc();
      bus_if.i_stop = (k == 10);
      smp();
      if (!bus_if.o_busy) begin seen = 1; break; end
      chk("fr_sclk", bus_if.o_sclk, (k / 2) & 1);
      k++;
    end
    bus_if.i_stop = 1'b0;
    chk("fr_seen_end", seen, 1);
    chk("fr_busy_len", k, 12);
    chk("fr_done", bus_if.o_done, 1);
    chk("fr_end_sclk", bus_if.o_sclk, 0);
    for (int t = 0; t < 6; t++) begin
      cyc();
      smp();
      chk("fr_quiet", {bus_if.o_sclk_rise, bus_if.o_sclk_fall, bus_if.o_busy, bus_if.o_done}, 0);
    end

    // Divider reload mid-period: 10-cycle period, then 4-cycle period
    prog(4, 0);
    start_burst(2);
    k = 0; seen = 0;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) cyc();
      bus_if.i_ld      = (k == 3);
      bus_if.i_ld_data = 16'd1;
      smp();
      if (!bus_if.o_busy) begin seen = 1; break; end
      chk("rl_sclk", bus_if.o_sclk, (k < 10) ? ((k / 5) & 1) : (((k - 10) / 2) & 1));
      k++;
    end
    bus_if.i_ld = 1'b0;
    chk("rl_seen_end", seen, 1);
    chk("rl_busy_len", k, 14);
    chk("rl_done", bus_if.o_done, 1);

    // Enable dropped on a terminal-count cycle
    prog(2, 1);
    start_burst(4);
    for (int t = 0; t < 8; t++) cyc();
    bus_if.i_module_en = 1'b0;
    smp();
    chk("en_gate_fall", bus_if.o_sclk_fall, 0);
    chk("en_gate_rise", bus_if.o_sclk_rise, 0);
    cyc();
    bus_if.i_start     = 1'b1;
    bus_if.i_burst_len = 8'd1;
    smp();
    chk("en_busy", bus_if.o_busy, 0);
    chk("en_sclk", bus_if.o_sclk, 1);
    chk("en_no_done", bus_if.o_done, 0);
    cyc();
    bus_if.i_start = 1'b0;
    smp();
    chk("en_start_ignored", bus_if.o_busy, 0);
    chk("en_no_done2", bus_if.o_done, 0);
    bus_if.i_module_en = 1'b1;
`ifdef PRESCALER_BURST_PCNT_EN
    chk("en_pcnt_hold", bus_if.o_period_cnt, 1);
`endif
    run_burst(2, 1, 1, 1'b0, busy_n, rises, falls, dones);
    chk("en_restart_busy", busy_n, 6);

    // Start accepted in the same cycle o_done is high
    prog(0, 0);
    start_burst(1);
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      smp();
      if (bus_if.o_done) begin seen = 1; break; end
      cyc();
    end
    chk("sd_done_seen", seen, 1);
    bus_if.i_start     = 1'b1;
    bus_if.i_burst_len = 8'd1;
    cyc();
    bus_if.i_start = 1'b0;
    smp();
    chk("sd_restart_busy", bus_if.o_busy, 1);
    chk("sd_done_clear", bus_if.o_done, 0);
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      cyc();
      smp();
      if (!bus_if.o_busy) begin seen = 1; break; end
    end
    chk("sd_second_end", seen, 1);
    chk("sd_second_done", bus_if.o_done, 1);

    // Randomized bursts with start noise during RUN
    for (int i = 0; i < 15; i++) begin
      div  = $urandom_range(0, 5);
      cpol = $urandom_range(0, 1);
      blen = $urandom_range(1, 4);
      run_burst(div, cpol, blen, 1'b1, busy_n, rises, falls, dones);
      chk("rnd_busy", busy_n, 2 * (div + 1) * blen);
      chk("rnd_rises", rises, blen);
      chk("rnd_falls", falls, blen);
      chk("rnd_dones", dones, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prescaler_burst.md
Name: prescaler_burst

Overview:
- Parametrised successor of the fixed 8-bit SCK prescaler.
- Generates a serial clock of programmable half-period, selectable idle polarity (CPOL) and either a fixed burst of N periods or free-running.
- Uses a start/busy/done handshake and shadows the divider so that reloads never glitch SCK.
- Drives SCK and edge strobes to serial-protocol engines (SPI/shift-register masters) on the system clock.

Parameters:
- DIV_W, 16: divider width; half-period = (div+1) system clocks.
- CNT_W, 8: burst-length and period-counter width.

Ports:
- i_sysclk  in  1  system clock.
- i_sysrst  in  1  asynchronous, active-high reset.
- i_module_en  in  1  module enable; low forces idle.
- i_ld  in  1  load divider value (pending register).
- i_ld_data  in  DIV_W  divider value.
- i_cpol  in  1  SCK idle level; sampled only in IDLE.
- i_start  in  1  start request; single-cycle or held.
- i_burst_len  in  CNT_W  number of SCK periods; 0 = free-running.
- i_stop  in  1  graceful stop request for free-running mode.
- o_sclk  out  1  serial clock.
- o_sclk_rise  out  1  strobe: SCK goes 0->1 on next i_sysclk edge.
- o_sclk_fall  out  1  strobe: SCK goes 1->0 on next i_sysclk edge.
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle pulse at burst/stop completion.

Behaviour:
- Reset (async):
  - div_pending=0, div_active=0, counter=0, periods=0, cpol_r=0, state=IDLE.
  - Outputs: o_sclk=0; o_sclk_rise, o_sclk_fall, o_busy, o_done = 0.
- Divider:
  - i_ld writes div_pending on the clock edge.
  - div_active <= div_pending in IDLE every cycle, and in RUN only at a trailing-edge terminal count.
  - Result: a period is never split across two divider values.
- IDLE:
  - counter held 0; cpol_r <= i_cpol each cycle; o_sclk = cpol_r.
  - i_start & i_module_en -> RUN next cycle; latch burst_len_r <= i_burst_len, periods <= 0.
- RUN:
  - counter increments each cycle; terminal count tc = (counter == div_active) -> counter <= 0 and phase toggles.
  - Leading edge: phase leaves cpol_r. Trailing edge: phase returns to cpol_r, periods++.
  - o_busy=1. i_start ignored.
  - o_sclk = phase XOR cpol_r.
- Edge strobes:
  - Combinational: o_sclk_rise = tc & RUN & (o_sclk==0); o_sclk_fall = tc & RUN & (o_sclk==1).
  - Each is asserted exactly one cycle before the corresponding SCK transition.
- Completion (checked only at a trailing-edge tc):
  - Fixed burst: burst_len_r!=0 and periods+1 == burst_len_r.
  - Free-running: burst_len_r==0 and stop_pend.
  - On completion: next state IDLE, o_done=1 for one cycle (registered), SCK rests at cpol_r.
- stop_pend:
  - Set by i_stop in RUN; cleared on entry to IDLE.
  - i_stop in IDLE is ignored.
  - In burst mode i_stop also ends the burst at the next trailing edge.
- Wrap-around: periods is CNT_W bits and wraps in free-running mode, with no effect on operation.
- i_module_en low (any state):
  - Next cycle state=IDLE, counter=0, o_sclk=cpol_r, stop_pend=0, no o_done pulse.
  - Strobes are gated low immediately.
- Simultaneous events:
  - i_ld with tc: the new value goes to pending and applies at the next eligible point.
  - i_start in the same cycle o_done is asserted: accepted, since the state is already IDLE.
- Minimum period is 2 system clocks (div=0); SCK duty is always 50%.

Optional Feature:
- Macro: PRESCALER_BURST_PCNT_EN
- Defined:
  - Adds output o_period_cnt [CNT_W-1:0], equal to the periods register (completed SCK periods of the current or last run).
  - Reset value 0, cleared on start.
  - Holds its value in IDLE after completion.
- Undefined:
  - Port absent.
  - periods register is kept only as wide as the completion compare needs; behaviour otherwise identical.

Test Plan:
- Reset mid-RUN with div=3, burst=5: assert i_sysrst at cycle 10 -> o_sclk=0, o_busy=0, no o_done, outputs 0 asynchronously.
- div=2, cpol=0, burst=3, start:
  - 3 rise and 3 fall strobes, SCK high/low 3 cycles each.
  - o_busy high for 18 cycles, then o_done for 1 cycle, then SCK=0.
- div=0, cpol=1, burst=2:
  - SCK idles at 1 and toggles every cycle, 4 transitions, fall strobe precedes rise.
  - Ends at 1, o_done once.
- burst=0, div=1, i_stop pulsed mid-high-phase -> run continues to end of current period, then o_done; no further strobes.
- Reload: div=4 running, i_ld data=1 mid-period -> current period stays 10 cycles; next period 4 cycles.
- i_module_en dropped during RUN -> next cycle IDLE, SCK=cpol, no o_done; re-enable plus start restarts burst from period 0 (o_period_cnt=0 when PRESCALER_BURST_PCNT_EN defined).
